rmii_recv_mem: RTL and testbench
================================

# rmii_recv_mem

Receive-side counterpart of the RMII memory transmitter. Samples RMII receive dibits from the PHY at 100 or 10 Mbit/s, strips preamble/SFD, assembles bytes LSB-first and writes them sequentially into a byte-wide frame buffer from address 0. On end of carrier it reports the byte count and status, then holds the buffer locked until the consumer releases it.

## Interface

- L, 8, address/count width; buffer holds at most 2^L-1 bytes
- clk  in  1  50 MHz RMII reference clock, the only clock
- rst  in  1  asynchronous, active-low reset
- fast_eth  in  1  speed: 0 = 10 Mbit/s, 1 = 100 Mbit/s; sampled only in st_idle
- rm_crs_dv  in  1  RMII carrier sense/data valid
- rm_rx_data  in  2  RMII receive dibit
- release  in  1  one-cycle strobe; consumer has read the buffer and unlocks it
- addr  out  L  buffer write address
- wdata  out  8  buffer write data
- we  out  1  buffer write enable, one cycle per byte
- count  out  L  bytes in last completed frame; valid from done until next frame start
- done  out  1  one-cycle pulse, frame finished
- err  out  1  frame status qualifying done, held with count: 1 = overflow or dribble
- rdy  out  1  1 = idle and unlocked, a new frame is accepted

## Operation

- Reset values: addr=0, wdata=0, we=0, count=0, done=0, err=0, rdy=1; state st_idle.
- Sample point: at 100 Mbit/s every clk. At 10 Mbit/s a 0..9 phase counter starts at 0 on the clk where rm_crs_dv is first seen high in st_idle; sample when phase==5, then every 10 clks.
- States:
  - st_idle: rdy=1. rm_crs_dv=1 -> st_pre, rdy<=0. rm_rx_data ignored here.
  - st_pre: sampled 01 -> stay; 11 after at least one 01 -> st_data, addr<=0, dibit counter<=0; 00 -> stay (PHY may present 00 before preamble); any other (10, or 11 with no prior 01) -> st_drop. crs_dv low at two consecutive samples -> st_idle, no done.
  - st_data: each sample with data taken shifts byte: b <= {dibit, b[7:2]}. After 4th dibit: wdata<=byte, we<=1, addr<=current index, index+1. Frame end: rm_crs_dv=0 at two consecutive samples (a single low sample is the RMII end-of-frame toggle; its dibit is taken as data). On end -> st_lock, count<=bytes written, done<=1, err<=1 if dibit counter not multiple of 4 (partial byte discarded, never written).
  - Overflow: a byte completing when 2^L-1 bytes already written is not written; err latched, -> st_drop; at end of carrier -> st_lock, count=2^L-1, done=1, err=1.
  - st_drop: ignore data until two consecutive low crs_dv samples; from preamble error -> st_idle without done; from overflow -> st_lock as above.
  - st_lock: rdy=0, frames on the wire ignored entirely (any carrier already high must fully end before next accept). release=1 -> st_idle, rdy<=1 next clk. release in other states ignored.
- addr arithmetic: L-bit, never wraps; index saturates by the overflow rule.
- fast_eth change while not in st_idle has no effect until st_idle.

## Timing

- we asserted the clk after the 4th dibit of a byte is sampled; addr/wdata valid in the same cycle as we; one cycle wide.
- First data byte written to addr 0; bytes at 100 Mbit/s spaced 4 clks, at 10 Mbit/s 40 clks.
- done asserted the clk after the second low crs_dv sample; count/err valid on and after that cycle.
- done and we never in the same cycle.
- release in the same cycle as done: ignored (lock entered that cycle).
- Asynchronous reset at any point: outputs to reset values immediately, partial frame discarded, next frame must begin with fresh carrier.

## Test plan

- 100 Mbit/s: 7x 55, D5, bytes 01 02 03 04 5A, crs_dv low -> we at addr 0..4 with 01,02,03,04,5A, done 1 cycle, count=5, err=0, rdy=0 until release.
- 10 Mbit/s, each dibit held 10 clks, same frame -> identical writes spaced 40 clks, count=5, err=0.
- Frame with crs_dv toggling 0/1 per dibit over last 2 bytes -> both bytes written, frame ends only on two lows, count correct.
- L=4, 20-byte payload -> 15 writes (addr 0..14), no further we, done with count=15, err=1.
- 3 bytes plus 2 extra dibits -> 3 writes, count=3, err=1; second frame arriving before release -> no we, no done; after release next frame received normally.
- Preamble containing 10 dibit -> no we, no done, back to rdy=1; rst low mid-frame -> we=0, addr=0, rdy=1 immediately.

Source files
------------

// File: rtl/rmii_recv_mem.sv
// rmii_recv_mem: RMII receiver that strips preamble/SFD and writes frame bytes into a buffer, locked until released.
module rmii_recv_mem #(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fast_eth,
  input  logic         rm_crs_dv,
  input  logic [1:0]   rm_rx_data,
  input  logic         buf_release,
  output logic [L-1:0] addr,
  output logic [7:0]   wdata,
  output logic         we,
  output logic [L-1:0] count,
  output logic         done,
  output logic         err,
  output logic         rdy
);
  typedef enum logic [2:0] {st_idle, st_pre, st_data, st_drop, st_lock} state_t;
  state_t state, state_n;
  logic fast, fast_n, crs_q, lowq, lowq_n, seen, seen_n, pendv, pendv_n, ovf, ovf_n;
  logic we_n, done_n, err_n, smp, cmpl;
  logic [3:0] ph, ph_n;
  logic [1:0] pend, pend_n, pos, pos_n, d0;
  logic [5:0] b, b_n;
  logic [7:0] b1, b2, wdata_n;
  logic [L-1:0] idx, idx_n, addr_n, count_n;
  assign smp = fast | (ph == 4'd5);
  // a dibit held from a single low sample is committed together with the next high one
  assign d0 = pendv ? pend : rm_rx_data;
  assign b1 = {d0, b};
  assign b2 = {rm_rx_data, b1[7:2]};
  assign cmpl = pos == 2'd3 || (pendv && pos == 2'd2);
  assign rdy = state == st_idle;
  always_comb begin
    state_n = state;
    fast_n = fast;
    ph_n = ph == 4'd9 ? 4'd0 : ph + 4'd1;
    lowq_n = lowq;
    seen_n = seen;
    pend_n = pend;
    pendv_n = pendv;
    pos_n = pos;
    b_n = b;
    idx_n = idx;
    ovf_n = ovf;
    addr_n = addr;
    wdata_n = wdata;
    we_n = 1'b0;
    count_n = count;
    done_n = 1'b0;
    err_n = err;
    case (state)
      st_idle: begin
        fast_n = fast_eth;
        if (rm_crs_dv && !crs_q) begin
          state_n = st_pre;
          ph_n = 4'd1;
          lowq_n = 1'b0;
          seen_n = 1'b0;
          ovf_n = 1'b0;
        end
      end
      st_pre: if (smp) begin
        lowq_n = !rm_crs_dv;
        if (!rm_crs_dv) state_n = lowq ? st_idle : st_pre;
        else if (rm_rx_data == 2'b01) seen_n = 1'b1;
        else if (rm_rx_data == 2'b11 && seen) begin
          state_n = st_data;
          addr_n = '0;
          idx_n = '0;
          pos_n = 2'd0;
          pendv_n = 1'b0;
        end else if (rm_rx_data != 2'b00) state_n = st_drop;
      end
      st_data: if (smp) begin
        lowq_n = !rm_crs_dv;
        if (!rm_crs_dv && lowq) begin
          state_n = st_lock;
          done_n = 1'b1;
          count_n = idx;
          err_n = pos != 2'd0;
        end else if (!rm_crs_dv) begin
          pend_n = rm_rx_data;
          pendv_n = 1'b1;
        end else begin
          pendv_n = 1'b0;
          b_n = pendv ? b2[7:2] : b1[7:2];
          pos_n = pos + {pendv, !pendv};
          if (cmpl && &idx) begin
            state_n = st_drop;
            ovf_n = 1'b1;
          end else if (cmpl) begin
            we_n = 1'b1;
            addr_n = idx;
            wdata_n = pos == 2'd3 ? b1 : b2;
            idx_n = idx + 1'b1;
          end
        end
      end
      st_drop: if (smp) begin
        lowq_n = !rm_crs_dv;
        if (!rm_crs_dv && lowq) begin
          state_n = ovf ? st_lock : st_idle;
          done_n = ovf;
          count_n = ovf ? idx : count;
          err_n = ovf | err;
        end
      end
      st_lock: state_n = buf_release && !done ? st_idle : st_lock;
      default: state_n = st_idle;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
      fast <= 1'b0;
      ph <= 4'd0;
      crs_q <= 1'b1;
      lowq <= 1'b0;
      seen <= 1'b0;
      pend <= 2'd0;
      pendv <= 1'b0;
      pos <= 2'd0;
      b <= '0;
      idx <= '0;
      ovf <= 1'b0;
      addr <= '0;
      wdata <= 8'd0;
      we <= 1'b0;
      count <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      fast <= fast_n;
      ph <= ph_n;
      crs_q <= rm_crs_dv;
      lowq <= lowq_n;
      seen <= seen_n;
      pend <= pend_n;
      pendv <= pendv_n;
      pos <= pos_n;
      b <= b_n;
      idx <= idx_n;
      ovf <= ovf_n;
      addr <= addr_n;
      wdata <= wdata_n;
      we <= we_n;
      count <= count_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_rmii_recv_mem.sv
// tb_rmii_recv_mem: table-driven and randomized frames checked against a byte-level model of the receiver.
module tb_rmii_recv_mem;
  localparam int L = 4;
  localparam int MAXB = 15;
  logic clk = 0, rst = 1, fast_eth = 1, rm_crs_dv = 0, buf_release = 0;
  logic [1:0] rm_rx_data = 0;
  logic [L-1:0] addr, count;
  logic [7:0] wdata;
  logic we, done, err, rdy;
  rmii_recv_mem #(.L(L)) dut (
    .clk(clk), .rst(rst), .fast_eth(fast_eth), .rm_crs_dv(rm_crs_dv), .rm_rx_data(rm_rx_data),
    .buf_release(buf_release), .addr(addr), .wdata(wdata), .we(we), .count(count), .done(done),
    .err(err), .rdy(rdy)
  );
  always #10 clk = ~clk;
  typedef struct {logic [L-1:0] a; logic [7:0] d; int c;} wr_t;
  typedef struct {logic crs; logic [1:0] d;} smp_t;
  typedef struct {bit f; int n; int extra; bit tog; bit bad; int ec; bit ee; bit ed;} vec_t;
  wr_t wq[$];
  smp_t sq[$];
  logic [7:0] pl[$];
  vec_t vt[8];
  int cyc = 0, ndone = 0, both = 0, vectors = 0, miscompares = 0;
  logic [L-1:0] dcount;
  logic derr;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst) begin
    if (we) wq.push_back('{addr, wdata, cyc});
    if (done) begin
      ndone <= ndone + 1;
      dcount <= count;
      derr <= err;
    end
    if (we && done) both <= both + 1;
  end
  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic model(input int n, input int extra, output int c, output bit e);
    c = n > MAXB ? MAXB : n;
    e = n > MAXB || extra % 4 != 0;
  endtask
  task automatic push_byte(input logic [7:0] v, input bit tog);
    for (int k = 0; k < 4; k++) sq.push_back('{!(tog && k % 2 == 0), v[2*k +: 2]});
  endtask
  task automatic run_frame(input bit f, input int n, input int extra, input bit tog, input bit bad);
    logic [7:0] fx [5];
    fx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h5A};
    pl.delete();
    sq.delete();
    for (int i = 0; i < n; i++) pl.push_back(i < 5 ? fx[i] : 8'($urandom));
    for (int i = 0; i < 8; i++) push_byte(i < 7 ? 8'h55 : 8'hD5, 0);
    if (bad) sq[2].d = 2'b10;
    for (int i = 0; i < n; i++) push_byte(pl[i], tog && i >= n - 2);
    for (int i = 0; i < extra; i++) sq.push_back('{1'b1, 2'($urandom)});
    for (int i = 0; i < 3; i++) sq.push_back('{1'b0, 2'b00});
    fast_eth = f;
    foreach (sq[i]) begin
      rm_crs_dv = sq[i].crs;
      rm_rx_data = sq[i].d;
      repeat (f ? 1 : 10) tick();
    end
    rm_crs_dv = 0;
    rm_rx_data = 0;
    repeat (20) tick();
  endtask
  task automatic release_buf;
    buf_release = 1;
    tick();
    buf_release = 0;
    chk("rdy after release", rdy, 1);
  endtask
  task automatic check_frame(input string nm, input bit f, input bit tog, input int wb, input int db,
                             input int ec, input bit ee, input bit ed, input bit rel);
    int nw;
    nw = wq.size() - wb;
    chk({nm, " writes"}, nw, ed ? ec : 0);
    for (int i = 0; i < nw && i < ec; i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), wq[wb+i].a, i);
      chk($sformatf("%s data[%0d]", nm, i), wq[wb+i].d, pl[i]);
      if (i > 0 && !tog) chk($sformatf("%s gap[%0d]", nm, i), wq[wb+i].c - wq[wb+i-1].c, f ? 4 : 40);
    end
    chk({nm, " done pulses"}, ndone - db, ed);
    if (ed) begin
      chk({nm, " count"}, dcount, ec);
      chk({nm, " err"}, derr, ee);
      chk({nm, " rdy locked"}, rdy, 0);
      if (rel) release_buf();
    end else chk({nm, " rdy idle"}, rdy, 1);
  endtask
  initial begin
    int wb, db, ec;
    bit ee, f, tog, seen;
    vt[0] = '{1, 5, 0, 0, 0, 5, 0, 1};
    vt[1] = '{0, 5, 0, 0, 0, 5, 0, 1};
    vt[2] = '{1, 6, 0, 1, 0, 6, 0, 1};
    vt[3] = '{0, 6, 0, 1, 0, 6, 0, 1};
    vt[4] = '{1, 20, 0, 0, 0, 15, 1, 1};
    vt[5] = '{1, 3, 2, 0, 0, 3, 1, 1};
    vt[6] = '{1, 4, 0, 0, 1, 0, 0, 0};
    vt[7] = '{0, 4, 0, 0, 1, 0, 0, 0};
    #2 rst = 0;
    #3;
    chk("reset addr", addr, 0);
    chk("reset wdata", wdata, 0);
    chk("reset we", we, 0);
    chk("reset count", count, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rdy", rdy, 1);
    @(posedge clk);
    #1 rst = 1;
    repeat (3) tick();
    foreach (vt[i]) begin
      wb = wq.size();
      db = ndone;
      run_frame(vt[i].f, vt[i].n, vt[i].extra, vt[i].tog, vt[i].bad);
      check_frame($sformatf("vec%0d", i), vt[i].f, vt[i].tog, wb, db, vt[i].ec, vt[i].ee, vt[i].ed, 1);
    end
    // a frame arriving while locked must be ignored completely
    wb = wq.size();
    db = ndone;
    run_frame(1, 3, 2, 0, 0);
    check_frame("dribble", 1, 0, wb, db, 3, 1, 1, 0);
    wb = wq.size();
    db = ndone;
    run_frame(1, 4, 0, 0, 0);
    chk("locked writes", wq.size() - wb, 0);
    chk("locked done", ndone - db, 0);
    chk("locked rdy", rdy, 0);
    release_buf();
    wb = wq.size();
    db = ndone;
    run_frame(0, 4, 0, 0, 0);
    check_frame("after lock", 0, 0, wb, db, 4, 0, 1, 1);
    // release coinciding with done is ignored
    wb = wq.size();
    db = ndone;
    seen = 0;
    fork
      run_frame(1, 4, 0, 0, 0);
      begin
        for (int i = 0; i < 500 && !seen; i++) begin
          tick();
          seen = done;
        end
        buf_release = 1;
        tick();
        buf_release = 0;
        chk("release with done rdy", rdy, 0);
      end
    join
    chk("done seen", seen, 1);
    check_frame("rel on done", 1, 0, wb, db, 4, 0, 1, 1);
    // asynchronous reset mid-frame, carrier keeps running afterwards
    fork
      run_frame(1, 10, 0, 0, 0);
      begin
        repeat (60) tick();
        #5 rst = 0;
        #1;
        chk("midrst we", we, 0);
        chk("midrst addr", addr, 0);
        chk("midrst rdy", rdy, 1);
        chk("midrst count", count, 0);
        wb = wq.size();
        db = ndone;
        tick();
        rst = 1;
      end
    join
    chk("post rst writes", wq.size() - wb, 0);
    chk("post rst done", ndone - db, 0);
    chk("post rst rdy", rdy, 1);
    for (int r = 0; r < 8; r++) begin
      int n, extra;
      f = 1'($urandom);
      tog = 1'($urandom);
      n = $urandom_range(1, 18);
      extra = $urandom_range(0, 3);
      model(n, extra, ec, ee);
      wb = wq.size();
      db = ndone;
      run_frame(f, n, extra, tog, 0);
      check_frame($sformatf("rand%0d", r), f, tog, wb, db, ec, ee, 1, 1);
    end
    chk("we with done", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
